// File: rtl/fetch_decode_execute_pkg.sv
// Shared encodings and the decode-to-execute bundle
// for the MIPS fetch/decode/execute front end.
package fetch_decode_execute_pkg;

  localparam logic [31:0] RA_RESET = 32'hdead_beef;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // aluop alone is ambiguous (funct and opcode spaces overlap),
  // so rtype tells execute which space aluop lives in.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] imm;
    logic        rtype;
    logic [5:0]  aluop;
    logic        br;
    logic        jp;
    logic        aluinb;
    logic        dmwe;
    logic        rwe;
    logic        rdst;
    logic        rwd;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '{insn: NOP_INSN, default: '0};

endpackage

// File: rtl/fetch_decode_execute_reg_file.sv
// 32x32 register file: two combinational read ports with
// write-first bypass, one synchronous write port.
module reg_file #(
  parameter logic [31:0] sp_init = 32'h8012_0000,
  parameter logic [31:0] ra_init = 32'hdead_beef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 29) ? sp_init :
                   (i == 31) ? ra_init : '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 :
                   (we && waddr == raddr_a) ? wdata :
                   regs[raddr_a];

  assign rdata_b = (raddr_b == 5'd0) ? '0 :
                   (we && waddr == raddr_b) ? wdata :
                   regs[raddr_b];

endmodule

// File: rtl/fetch_decode_execute.sv
// MIPS front end: fetch, decode, D->X register and execute,
// with branches resolved in X behind one delay slot.
module fetch_decode_execute #(
  parameter logic [31:0] base_addr = 32'h8002_0000,
  parameter logic [31:0] mem_depth = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] i_address,
  output logic [1:0]  i_access_size,
  output logic        i_rw,
  output logic        i_mem_enable,
  input  logic [31:0] i_insn,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic [31:0] pc_fd,
  output logic [31:0] pc_x,
  output logic [31:0] insn_x,
  output logic [31:0] alu_out,
  output logic [31:0] rb_out,
  output logic        dmwe_x,
  output logic        rwe_x,
  output logic        rdst_x,
  output logic        rwd_x,
  output logic [4:0]  dest_x,
  output logic [31:0] pc_effective,
  output logic        do_branch
);

  import fetch_decode_execute_pkg::*;

  logic [31:0] pc;
  logic [31:0] ra_val;
  logic [31:0] rb_val;
  logic [5:0]  op;
  logic [5:0]  fn;
  id_ex_t      d;
  id_ex_t      x;

  assign op = i_insn[31:26];
  assign fn = i_insn[5:0];

  assign i_address     = pc;
  assign i_access_size = 2'b00;
  assign i_rw          = 1'b1;
  assign i_mem_enable  = 1'b1;
  assign pc_fd         = pc;

  // A redirect wins even under stall so the target is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pc <= base_addr;
    else if (do_branch)
      pc <= pc_effective;
    else if (!stall)
      pc <= pc + 32'd4;
  end

  reg_file #(
    .sp_init (base_addr + mem_depth),
    .ra_init (RA_RESET)
  ) u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_dest),
    .wdata   (wb_data),
    .raddr_a (i_insn[25:21]),
    .rdata_a (ra_val),
    .raddr_b (i_insn[20:16]),
    .rdata_b (rb_val)
  );

  always_comb begin
    d        = BUBBLE;
    d.pc     = pc;
    d.insn   = i_insn;
    d.ra     = ra_val;
    d.rb     = rb_val;
    d.rtype  = (op == OP_SPECIAL);
    d.aluop  = d.rtype ? fn : op;
    d.imm    = {{16{i_insn[15]}}, i_insn[15:0]};
    unique case (op)
      OP_SPECIAL: begin
        unique case (fn)
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL,
          F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            d.rwe  = 1'b1;
            d.rdst = 1'b1;
          end
          F_JR:
            d.jp = 1'b1;
          F_JALR: begin
            d.jp   = 1'b1;
            d.rwe  = 1'b1;
            d.rdst = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REGIMM:
        d.br = (i_insn[20:16] == RT_BLTZ) ||
               (i_insn[20:16] == RT_BGEZ);
      OP_J:
        d.jp = 1'b1;
      OP_JAL: begin
        d.jp  = 1'b1;
        d.rwe = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        d.br = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        d.aluinb = 1'b1;
        d.rwe    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.aluinb = 1'b1;
        d.rwe    = 1'b1;
        d.imm    = {16'h0, i_insn[15:0]};
      end
      OP_LUI: begin
        d.aluinb = 1'b1;
        d.rwe    = 1'b1;
        d.imm    = {i_insn[15:0], 16'h0};
      end
      OP_LB, OP_LW, OP_LBU: begin
        d.aluinb = 1'b1;
        d.rwe    = 1'b1;
        d.rwd    = 1'b1;
      end
      OP_SB, OP_SW: begin
        d.aluinb = 1'b1;
        d.dmwe   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      x <= BUBBLE;
    else
      x <= stall ? BUBBLE : d;
  end

  logic [31:0] opb;
  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [4:0]  shamt;
  logic        link;
  logic        taken;

  assign opb    = x.aluinb ? x.imm : x.rb;
  assign pc4    = x.pc + 32'd4;
  assign br_tgt = pc4 + {x.imm[29:0], 2'b00};
  assign j_tgt  = {pc4[31:28], x.insn[25:0], 2'b00};
  assign shamt  = x.insn[10:6];
  assign link   = !x.rtype && x.aluop == OP_JAL;

  always_comb begin
    alu_out = x.ra + opb;
    if (x.rtype) begin
      unique case (x.aluop)
        F_SUB, F_SUBU: alu_out = x.ra - x.rb;
        F_AND:  alu_out = x.ra & x.rb;
        F_OR:   alu_out = x.ra | x.rb;
        F_XOR:  alu_out = x.ra ^ x.rb;
        F_NOR:  alu_out = ~(x.ra | x.rb);
        F_SLT:  alu_out = {31'b0, $signed(x.ra) < $signed(x.rb)};
        F_SLTU: alu_out = {31'b0, x.ra < x.rb};
        F_SLL:  alu_out = x.rb << shamt;
        F_SRL:  alu_out = x.rb >> shamt;
        F_SRA:  alu_out = $unsigned($signed(x.rb) >>> shamt);
        F_SLLV: alu_out = x.rb << x.ra[4:0];
        F_SRLV: alu_out = x.rb >> x.ra[4:0];
        F_SRAV: alu_out = $unsigned($signed(x.rb) >>> x.ra[4:0]);
        F_JALR: alu_out = x.pc + 32'd8;
        default: ;
      endcase
    end else begin
      unique case (x.aluop)
        OP_SLTI:  alu_out = {31'b0, $signed(x.ra) < $signed(opb)};
        OP_SLTIU: alu_out = {31'b0, x.ra < opb};
        OP_ANDI:  alu_out = x.ra & opb;
        OP_ORI:   alu_out = x.ra | opb;
        OP_XORI:  alu_out = x.ra ^ opb;
        OP_LUI:   alu_out = opb;
        OP_JAL:   alu_out = x.pc + 32'd8;
        default: ;
      endcase
    end
  end

  always_comb begin
    taken = 1'b0;
    if (x.br) begin
      unique case (x.aluop)
        OP_BEQ:    taken = (x.ra == x.rb);
        OP_BNE:    taken = (x.ra != x.rb);
        OP_BLEZ:   taken = x.ra[31] || (x.ra == '0);
        OP_BGTZ:   taken = !x.ra[31] && (x.ra != '0);
        OP_REGIMM: taken = (x.insn[20:16] == RT_BGEZ) ?
                           !x.ra[31] : x.ra[31];
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (1'b1)
      x.jp &&  x.rtype: pc_effective = x.ra;
      x.jp && !x.rtype: pc_effective = j_tgt;
      default:          pc_effective = br_tgt;
    endcase
  end

  assign do_branch = x.jp || taken;
  assign dest_x    = link   ? 5'd31 :
                     x.rdst ? x.insn[15:11] : x.insn[20:16];
  assign pc_x      = x.pc;
  assign insn_x    = x.insn;
  assign rb_out    = x.rb;
  assign dmwe_x    = x.dmwe;
  assign rwe_x     = x.rwe;
  assign rdst_x    = x.rdst;
  assign rwd_x     = x.rwd;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Scoreboard bench: stimulus pushes ISA-level expectations,
// a monitor pops and compares the X-stage view each cycle.
module tb_fetch_decode_execute;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam logic [31:0] SP0  = 32'h8012_0000;
  localparam logic [31:0] RA0  = 32'hdead_beef;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] i_insn = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] i_address, pc_fd, pc_x, insn_x;
  logic [31:0] alu_out, rb_out, pc_effective;
  logic [1:0]  i_access_size;
  logic        i_rw, i_mem_enable;
  logic        dmwe_x, rwe_x, rdst_x, rwd_x, do_branch;
  logic [4:0]  dest_x;

  always #5 clock = ~clock;

  fetch_decode_execute dut (
    .clock(clock), .reset(reset), .stall(stall),
    .i_address(i_address), .i_access_size(i_access_size),
    .i_rw(i_rw), .i_mem_enable(i_mem_enable), .i_insn(i_insn),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .pc_fd(pc_fd), .pc_x(pc_x), .insn_x(insn_x),
    .alu_out(alu_out), .rb_out(rb_out),
    .dmwe_x(dmwe_x), .rwe_x(rwe_x), .rdst_x(rdst_x), .rwd_x(rwd_x),
    .dest_x(dest_x), .pc_effective(pc_effective), .do_branch(do_branch)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] alu;
    logic [31:0] rb;
    logic [31:0] target;
    logic [31:0] pc_fd;
    logic [4:0]  dest;
    logic        rwe, dmwe, rwd, rdst;
    logic        aluv, tgtv, taken, bubble, link;
  } exp_t;

  exp_t        q[$];
  exp_t        cur_x;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  int          n_pass = 0;
  int          n_total = 0;

  logic [5:0] fn_tab [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
    6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03,
    6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h3f};
  logic [5:0] op_tab [22] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
    6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
    6'h0e, 6'h0f, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2b, 6'h10, 6'h3f};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ISA-level meaning of one instruction given its source values.
  function automatic exp_t ref_exec(input logic [31:0] pc, insn, a, b);
    exp_t e;
    logic [31:0] se, ze, pc4;
    logic [4:0] sh;
    e = '0;
    e.pc = pc; e.insn = insn; e.rb = b;
    se = {{16{insn[15]}}, insn[15:0]};
    ze = {16'h0, insn[15:0]};
    pc4 = pc + 32'd4;
    sh = insn[10:6];
    case (insn[31:26])
      6'h00: begin
        e.rwe = 1; e.rdst = 1; e.aluv = 1; e.dest = insn[15:11];
        case (insn[5:0])
          6'h20, 6'h21: e.alu = a + b;
          6'h22, 6'h23: e.alu = a - b;
          6'h24: e.alu = a & b;
          6'h25: e.alu = a | b;
          6'h26: e.alu = a ^ b;
          6'h27: e.alu = ~(a | b);
          6'h2a: e.alu = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h2b: e.alu = (a < b) ? 1 : 0;
          6'h00: e.alu = b << sh;
          6'h02: e.alu = b >> sh;
          6'h03: e.alu = 32'($signed(b) >>> sh);
          6'h04: e.alu = b << a[4:0];
          6'h06: e.alu = b >> a[4:0];
          6'h07: e.alu = 32'($signed(b) >>> a[4:0]);
          6'h08: begin
            e.rwe = 0; e.rdst = 0; e.aluv = 0;
            e.tgtv = 1; e.taken = 1; e.target = a;
          end
          6'h09: begin
            e.tgtv = 1; e.taken = 1; e.target = a; e.alu = pc + 32'd8;
          end
          default: begin e.rwe = 0; e.rdst = 0; e.aluv = 0; end
        endcase
      end
      6'h01: if (insn[20:17] == 4'b0) begin
        e.tgtv = 1; e.target = pc4 + (se << 2);
        e.taken = insn[16] ? ~a[31] : a[31];
      end
      6'h02, 6'h03: begin
        e.tgtv = 1; e.taken = 1;
        e.target = {pc4[31:28], insn[25:0], 2'b00};
        if (insn[26]) begin
          e.link = 1; e.rwe = 1; e.dest = 5'd31;
          e.aluv = 1; e.alu = pc + 32'd8;
        end
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        e.tgtv = 1; e.target = pc4 + (se << 2);
        case (insn[27:26])
          2'd0: e.taken = (a == b);
          2'd1: e.taken = (a != b);
          2'd2: e.taken = ($signed(a) <= 32'sd0);
          default: e.taken = ($signed(a) > 32'sd0);
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        e.rwe = 1; e.aluv = 1; e.dest = insn[20:16];
        case (insn[28:26])
          3'd0, 3'd1: e.alu = a + se;
          3'd2: e.alu = ($signed(a) < $signed(se)) ? 1 : 0;
          3'd3: e.alu = (a < se) ? 1 : 0;
          3'd4: e.alu = a & ze;
          3'd5: e.alu = a | ze;
          3'd6: e.alu = a ^ ze;
          default: e.alu = {insn[15:0], 16'h0};
        endcase
      end
      6'h20, 6'h23, 6'h24: begin
        e.rwe = 1; e.rwd = 1; e.aluv = 1;
        e.dest = insn[20:16]; e.alu = a + se;
      end
      6'h28, 6'h2b: begin
        e.dmwe = 1; e.aluv = 1; e.alu = a + se;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t bubble_exp();
    exp_t e;
    e = '0;
    e.bubble = 1;
    e.aluv = 1;
    return e;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] r,
      input logic we, input logic [4:0] dst, input logic [31:0] dat);
    if (r == 5'd0) return '0;
    if (we && dst == r) return dat;
    return m_regs[r];
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      r[25:21] = {2'b0, r[23:21]};
      r[20:16] = {2'b0, r[18:16]};
    end
    if ($urandom_range(0, 1) == 0) begin
      r[31:26] = 6'h00;
      r[5:0] = fn_tab[$urandom_range(0, 18)];
    end else begin
      r[31:26] = op_tab[$urandom_range(0, 21)];
      if (r[31:26] == 6'h01 && $urandom_range(0, 3) != 0)
        r[20:17] = 4'b0;
    end
    return r;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_regs[29] = SP0;
    m_regs[31] = RA0;
    m_pc = BASE;
    cur_x = bubble_exp();
  endtask

  task automatic step(input logic [31:0] insn, input logic we,
      input logic [4:0] dst, input logic [31:0] dat, input logic stl);
    exp_t e;
    logic [31:0] a, b, nxt;
    @(negedge clock); #1;
    i_insn = insn; wb_we = we; wb_dest = dst;
    wb_data = dat; stall = stl;
    a = rd_model(insn[25:21], we, dst, dat);
    b = rd_model(insn[20:16], we, dst, dat);
    e = stl ? bubble_exp() : ref_exec(m_pc, insn, a, b);
    nxt = cur_x.taken ? cur_x.target : (stl ? m_pc : m_pc + 32'd4);
    if (we && dst != 5'd0) m_regs[dst] = dat;
    e.pc_fd = nxt;
    q.push_back(e);
    cur_x = e;
    m_pc = nxt;
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset = 1; wb_we = 0; stall = 0; i_insn = '0;
    q.delete();
    model_init();
    #1;
    chk("rst_pc_fd", pc_fd, BASE);
    chk("rst_do_branch", 32'(do_branch), 0);
    chk("rst_rwe_x", 32'(rwe_x), 0);
    chk("rst_dmwe_x", 32'(dmwe_x), 0);
    chk("rst_alu_out", alu_out, 0);
    chk("i_access_size", 32'(i_access_size), 0);
    chk("i_rw", 32'(i_rw), 1);
    chk("i_mem_enable", 32'(i_mem_enable), 1);
    @(posedge clock); #1;
    reset = 0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("pc_fd", pc_fd, e.pc_fd);
        chk("i_address", i_address, e.pc_fd);
        chk("insn_x", insn_x, e.insn);
        if (!e.bubble) chk("pc_x", pc_x, e.pc);
        if (e.aluv) chk("alu_out", alu_out, e.alu);
        chk("rb_out", rb_out, e.rb);
        chk("rwe_x", 32'(rwe_x), 32'(e.rwe));
        chk("dmwe_x", 32'(dmwe_x), 32'(e.dmwe));
        chk("rwd_x", 32'(rwd_x), 32'(e.rwd));
        if (e.rwe) chk("dest_x", 32'(dest_x), 32'(e.dest));
        if (e.rwe && !e.link) chk("rdst_x", 32'(rdst_x), 32'(e.rdst));
        chk("do_branch", 32'(do_branch), 32'(e.taken));
        if (e.tgtv) chk("pc_effective", pc_effective, e.target);
      end
    end
  end

  initial begin
    logic [4:0] dst;
    do_reset();
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    step({6'h00, 5'd29, 5'd0, 5'd3, 5'd0, 6'h21}, 0, 0, 0, 0);
    step({6'h00, 5'd31, 5'd0, 5'd4, 5'd0, 6'h21}, 0, 0, 0, 0);
    step({6'h04, 5'd0, 5'd0, 16'd3}, 0, 0, 0, 0);
    step({6'h08, 5'd0, 5'd1, 16'd5}, 0, 0, 0, 0);
    step(32'h0, 1, 5'd1, 32'd5, 0);
    step({6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20}, 0, 0, 0, 0);
    step({6'h2b, 5'd29, 5'd2, 16'd8}, 1, 5'd2, 32'hA, 0);
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    do_reset();
    step({6'h03, 26'h0008010}, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 1);
    step(32'h0, 0, 0, 0, 1);
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        dst = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7))
                                          : 5'($urandom_range(0, 31));
        step(rand_insn(), 1'($urandom_range(0, 1)), dst, $urandom,
             ($urandom_range(0, 9) == 0));
      end
    end
    @(negedge clock); #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_decode_execute.md
# fetch_decode_execute

Front end of the 5-stage MIPS pipeline: fetch (PC and instruction-memory request), decode (register file and control generation), the D→X pipeline register, and execute (ALU and branch/jump resolution). It feeds the memory/writeback stages and accepts register writes back from writeback. Branches and jumps resolve in X with exactly one architectural delay slot, so no flush logic is needed.

## Interface
- base_addr, 32'h80020000: reset PC; base of text/data region
- mem_depth, 32'h00100000: memory size in bytes; r29 resets to base_addr + mem_depth
- clock  in  1  sole clock, all state updates on posedge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC; inject bubble into D→X
- i_address  out  32  instruction fetch address (= pc_fd)
- i_access_size  out  2  constant 2'b00 (word)
- i_rw  out  1  constant 1 (read)
- i_mem_enable  out  1  constant 1
- i_insn  in  32  instruction at i_address, valid same cycle
- wb_we, wb_dest[4:0], wb_data[31:0]  in  register write port from writeback
- pc_fd  out  32  PC of instruction in decode
- pc_x, insn_x  out  32 each  PC / instruction in execute
- alu_out, rb_out  out  32 each  ALU result; store data (rB of X)
- dmwe_x, rwe_x, rdst_x, rwd_x  out  1 each  control of X instruction
- dest_x  out  5  resolved write register (rd, rt or 31)
- pc_effective  out  32  redirect target; do_branch  out  1  redirect taken

## Operation
- Fetch: pc_fd register. Posedge, stall=0: pc <= do_branch ? pc_effective : pc+4. stall=1: hold (redirect still applied if do_branch).
- Decode: rA = R[rs], rB = R[rt], combinational; r0 always reads 0; write-first bypass when wb_we and wb_dest matches.
- Register file: 32x32, synchronous write on posedge when wb_we and wb_dest≠0.
- Controls: br (conditional branch), jp (J/JAL/JR/JALR), aluinb (1 = immediate operand B), aluop[5:0] (= funct for R-type, = opcode otherwise), dmwe (store), rwe (writes reg), rdst (1 = rd, 0 = rt), rwd (1 = load data to reg).
- Supported: R-type ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV/JR/JALR; ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI; LW/LB/LBU/SW/SB; BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ; J/JAL. Unknown opcodes decode as NOP (all enables 0).
- Immediates: sign-extend for arith/compare/load/store/branch; zero-extend for ANDI/ORI/XORI; LUI = imm<<16.
- Arithmetic: 32-bit wrap, no overflow traps; SLT signed, SLTU unsigned; shifts use shamt or rs[4:0].
- Loads/stores: alu_out = rA + sext(imm).
- Targets: branch = pc_x+4+(sext(imm)<<2); J/JAL = {pc_x[31:28]+..., i.e. (pc_x+4)[31:28], index, 2'b00}; JR/JALR = rA.
- Link: JAL/JALR alu_out = pc_x+8; JAL dest_x = 31, JALR dest = rd.

## Timing
- Fetch→decode combinational; D→X register on posedge; execute combinational from D→X.
- Branch/jump in X while delay slot sits in decode; next posedge PC = target: one delay slot, zero extra bubbles.
- stall=1: D→X loads bubble (insn 0, all enables and br/jp 0).
- Reset (async, any time): pc_fd = base_addr; D→X = bubble, so do_branch=0, rwe_x=dmwe_x=0, alu_out = 0; registers all 0 except r29 = base_addr+mem_depth, r31 = 32'hdeadbeef.
- Simultaneous wb write and decode read of same register: new value seen.

## Structure
- Shared package: opcode, funct, REGIMM rt codes, aluop constants, NOP encoding.
- Sub-module reg_file (32x32, 2 read, 1 write, reset init); fetch, decode, execute logic in one module otherwise.

## Test plan
- Reset release, i_insn=0 -> pc_fd 80020000, 80020004, 80020008 on successive posedges; r29 reads 80120000, r31 deadbeef.
- ADDI r1,r0,5 then wb_we r1=5; ADD r2,r1,r1 -> alu_out 0000000A, rdst_x=1, dest_x=2.
- BEQ r0,r0,+3 at 80020010 -> do_branch=1, pc_effective 80020020; delay slot 80020014 decoded; then pc_fd 80020020.
- JAL at 80020000 index 0x0008010 -> pc_effective 80020040, alu_out 80020008, dest_x 31.
- SW r2,8(r29) with r29=80120000 -> alu_out 80120008, dmwe_x=1, rwe_x=0, rb_out = R[2].
- stall held 2 cycles -> pc_fd unchanged, rwe_x=dmwe_x=0; assert reset mid-run -> pc_fd 80020000 immediately.
